// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer among
// N_REQ byte sources, with an optional packet lock that keeps the grant on one
// requester until it sends a byte marked last.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LOCK_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*8-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done_tick,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_ptr;
    logic             r_lock;
    logic [IDW-1:0]   r_lock_id;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic             w_accept;
    logic [7:0]       w_data;
    logic             w_last;

    // Round-robin search from ptr+1 upward; while locked only lock_id is eligible.
    always_comb begin
        int j;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_win   = '0;
        j       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!w_found && req_valid[j] && (!r_lock || (r_lock_id == IDW'(j)))) begin
                w_found = 1'b1;
                w_win   = IDW'(j);
            end
        end
        w_data = req_data[int'(w_win)*8 +: 8];
        w_last = req_last[w_win];
    end

    // Next-state logic: accept in IDLE, one START cycle, then wait for the frame end.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: w_state_next = S_WAIT;
            S_WAIT: begin
                if (tx_done_tick) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the accepted byte, grant, round-robin pointer and packet lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_grant_id <= '0;
            r_ptr      <= IDW'(N_REQ - 1);
            r_lock     <= 1'b0;
            r_lock_id  <= '0;
        end else begin
            r_tx_start <= w_accept;
            if (w_accept) begin
                r_tx_data  <= w_data;
                r_grant_id <= w_win;
                r_ptr      <= w_win;
                if (LOCK_EN != 0) begin
                    r_lock    <= ~w_last;
                    r_lock_id <= w_win;
                end
            end
        end
    end

    assign req_ready = w_accept ? (N_REQ'(1) << w_win) : '0;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a simple serializer model returns
// tx_done_tick a fixed time after each tx_start; a scoreboard of expected
// (requester, byte) pairs is filled as stimulus is driven and consumed on
// every observed tx_start.
module tb_uart_tx_arbiter;

    localparam int FRAME = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done_tick;
    logic [1:0]  grant_id;
    logic        busy;

    logic        m_tick;
    logic        spur_tick;
    int          m_cnt;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int done_cyc = 0;
    bit done_seen = 1'b0;
    bit gap_en    = 1'b0;

    always #5 clk = ~clk;

    assign tx_done_tick = m_tick | spur_tick;

    uart_tx_arbiter #(.N_REQ(4), .LOCK_EN(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // Serializer model: one frame of FRAME cycles per tx_start, ends with a done pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_tick <= 1'b0;
        end else begin
            m_tick <= 1'b0;
            if (tx_start) begin
                m_cnt <= FRAME;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_tick <= 1'b1;
                end
            end
        end
    end

    // Observe at the falling edge: ready legality every cycle, scoreboard on tx_start.
    task automatic sample();
        @(negedge clk);
        if (!reset_n) begin
            done_seen = 1'b0;
        end else begin
            checks++;
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 4'b0)) begin
                errors++;
                $display("FAIL ready_legal cyc %0d req_ready %b req_valid %b", cyc, req_ready, req_valid);
            end
            if (tx_start) begin
                n_starts++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start cyc %0d tx_data %h grant_id %0d", cyc, tx_data, grant_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (tx_data !== e.data) begin
                        errors++;
                        $display("FAIL tx_data cyc %0d got %h exp %h", cyc, tx_data, e.data);
                    end
                    checks++;
                    if (grant_id !== e.id) begin
                        errors++;
                        $display("FAIL grant_id cyc %0d got %0d exp %0d", cyc, grant_id, e.id);
                    end
                end
                if (gap_en && done_seen) begin
                    checks++;
                    if ((cyc - done_cyc) !== 2) begin
                        errors++;
                        $display("FAIL start_gap cyc %0d got %0d exp 2", cyc, cyc - done_cyc);
                    end
                end
            end
            if (tx_done_tick) begin
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ends at the falling edge of the acceptance cycle; caller advances.
    task automatic wait_accept(input logic [3:0] forbid, input int budget,
                               output logic [3:0] got, output bit bad);
        int n;
        got = 4'b0;
        bad = 1'b0;
        n   = 0;
        while (1) begin
            sample();
            if ((req_ready & forbid) != 4'b0) bad = 1'b1;
            if ((req_valid & req_ready) != 4'b0) begin
                got = req_ready;
                break;
            end
            n++;
            if (n >= budget) break;
            advance();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            sample();
            if (!busy && !tx_start && (m_cnt == 0) && (sb.size() == 0)) begin
                ok = 1'b1;
            end
            advance();
            n++;
            if (ok) break;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout busy %b pending %0d", busy, sb.size());
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0;
        req_last  = 4'b0;
        req_data  = 32'h0;
        spur_tick = 1'b0;
        sample();
        advance();
        sample();
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 4'b0;
        req_last  = 4'b0;
        req_data  = 32'h0;
        spur_tick = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_data, req_ready, grant_id, busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_values got start %b data %h ready %b grant %0d busy %b",
                     tx_start, tx_data, req_ready, grant_id, busy);
        end
        sample();
        advance();
        reset_n = 1'b1;
        sample();
        checks++;
        if ({tx_start, busy, req_ready} !== 6'b0) begin
            errors++;
            $display("FAIL after_release got start %b busy %b ready %b", tx_start, busy, req_ready);
        end
        advance();
    endtask

    task automatic test_single_byte();
        int  s0;
        bit  seen;
        do_reset();
        s0 = n_starts;
        sb.push_back('{id: 2'd2, data: 8'h5A});
        req_data[23:16] = 8'h5A;
        req_last        = 4'b0100;
        req_valid       = 4'b0100;
        sample();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready got %b exp 0100", req_ready);
        end
        advance();
        sample();
        checks++;
        if ({req_ready, tx_start, busy} !== {4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_start got ready %b start %b busy %b exp 0000 1 1", req_ready, tx_start, busy);
        end
        advance();
        req_valid = 4'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (tx_done_tick) begin
                seen = 1'b1;
                break;
            end
            advance();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_done_timeout got 0 exp 1");
        end
        advance();
        sample();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop got %b exp 0", busy);
        end
        advance();
        checks++;
        if (n_starts !== s0 + 1) begin
            errors++;
            $display("FAIL single_start_count got %0d exp %0d", n_starts - s0, 1);
        end
    endtask

    task automatic test_round_robin();
        int s0;
        int n;
        do_reset();
        s0 = n_starts;
        req_data  = 32'h13121110;
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        sb.push_back('{id: 2'd0, data: 8'h10});
        sb.push_back('{id: 2'd1, data: 8'h11});
        sb.push_back('{id: 2'd2, data: 8'h12});
        sb.push_back('{id: 2'd3, data: 8'h13});
        sb.push_back('{id: 2'd0, data: 8'h10});
        gap_en = 1'b1;
        n = 0;
        while ((n_starts < s0 + 5) && (n < 300)) begin
            sample();
            advance();
            n++;
        end
        req_valid = 4'b0;
        checks++;
        if (n_starts !== s0 + 5) begin
            errors++;
            $display("FAIL rr_start_count got %0d exp 5", n_starts - s0);
        end
        wait_idle(100);
        gap_en = 1'b0;
    endtask

    task automatic test_packet_lock();
        logic [3:0] got;
        bit         bad;
        do_reset();
        sb.push_back('{id: 2'd1, data: 8'hA0});
        sb.push_back('{id: 2'd1, data: 8'hA1});
        sb.push_back('{id: 2'd1, data: 8'hA2});
        sb.push_back('{id: 2'd0, data: 8'h0C});
        req_data[15:8] = 8'hA0;
        req_last       = 4'b0000;
        req_valid      = 4'b0010;
        wait_accept(4'b0000, 50, got, bad);
        checks++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL lock_a0 got %b exp 0010", got);
        end
        advance();
        req_data[7:0]  = 8'h0C;
        req_last       = 4'b0001;
        req_valid      = 4'b0011;
        req_data[15:8] = 8'hA1;
        wait_accept(4'b0001, 200, got, bad);
        checks++;
        if ({got, bad} !== {4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL lock_a1 got %b bad %b exp 0010 0", got, bad);
        end
        advance();
        req_data[15:8] = 8'hA2;
        req_last       = 4'b0011;
        wait_accept(4'b0001, 200, got, bad);
        checks++;
        if ({got, bad} !== {4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL lock_a2 got %b bad %b exp 0010 0", got, bad);
        end
        advance();
        req_valid = 4'b0001;
        wait_accept(4'b0000, 200, got, bad);
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL lock_release got %b exp 0001", got);
        end
        advance();
        req_valid = 4'b0;
        wait_idle(100);
    endtask

    task automatic test_lock_stall();
        logic [3:0] got;
        bit         bad;
        int         s0;
        int         n;
        do_reset();
        sb.push_back('{id: 2'd3, data: 8'h33});
        sb.push_back('{id: 2'd3, data: 8'h34});
        sb.push_back('{id: 2'd0, data: 8'h0D});
        req_data[31:24] = 8'h33;
        req_last        = 4'b0000;
        req_valid       = 4'b1000;
        wait_accept(4'b0000, 50, got, bad);
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL stall_first got %b exp 1000", got);
        end
        advance();
        req_data[7:0] = 8'h0D;
        req_last      = 4'b0001;
        req_valid     = 4'b0001;
        n = 0;
        while (n < 100) begin
            sample();
            advance();
            n++;
            if (!busy) break;
        end
        s0  = n_starts;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if ((req_ready != 4'b0) || busy) bad = 1'b1;
            advance();
        end
        checks++;
        if ({bad, n_starts - s0} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL stall_hold got activity %b starts %0d exp 0 0", bad, n_starts - s0);
        end
        req_data[31:24] = 8'h34;
        req_last        = 4'b1001;
        req_valid       = 4'b1001;
        wait_accept(4'b0001, 20, got, bad);
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL stall_resume got %b exp 1000", got);
        end
        advance();
        req_valid = 4'b0001;
        wait_accept(4'b0000, 200, got, bad);
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL stall_release got %b exp 0001", got);
        end
        advance();
        req_valid = 4'b0;
        wait_idle(100);
    endtask

    task automatic test_spurious_and_reset();
        logic [3:0] got;
        bit         bad;
        do_reset();
        spur_tick = 1'b1;
        sample();
        advance();
        spur_tick = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            if (busy || tx_start) bad = 1'b1;
            advance();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL spurious_tick got activity 1 exp 0");
        end
        sb.push_back('{id: 2'd2, data: 8'h22});
        req_data[23:16] = 8'h22;
        req_last        = 4'b0000;
        req_valid       = 4'b0100;
        wait_accept(4'b0000, 20, got, bad);
        checks++;
        if (got !== 4'b0100) begin
            errors++;
            $display("FAIL mid_accept got %b exp 0100", got);
        end
        advance();
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            advance();
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b exp 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_data, req_ready, grant_id, busy} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got start %b data %h ready %b grant %0d busy %b",
                     tx_start, tx_data, req_ready, grant_id, busy);
        end
        sample();
        advance();
        reset_n = 1'b1;
        sb.push_back('{id: 2'd0, data: 8'h0E});
        sb.push_back('{id: 2'd2, data: 8'h23});
        req_data[7:0]   = 8'h0E;
        req_data[23:16] = 8'h23;
        req_last        = 4'b0101;
        req_valid       = 4'b0101;
        wait_accept(4'b0000, 20, got, bad);
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_first got %b exp 0001", got);
        end
        advance();
        req_valid = 4'b0100;
        wait_accept(4'b0000, 200, got, bad);
        checks++;
        if (got !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_second got %b exp 0100", got);
        end
        advance();
        req_valid = 4'b0;
        wait_idle(100);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_lock_stall();
        test_spurious_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
